input_debounce: RTL and testbench

Input-side I/O stage of the memory-mapped peripheral path. It takes the raw asynchronous switch and push-button pins and synchronizes and debounces them. It presents the results as the 32-bit `b_io_sw` and `b_io_btn` buffers that the load-data multiplexer returns on I/O reads. It also keeps sticky per-button press flags, which are cleared by a processor load from the button region (0x1001_1xxx).

---
 rtl/input_debounce.sv | 97 +++++++++
 tb/tb_input_debounce.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// Switch/button input stage: pin synchronization, per-bit debounce and sticky
// button press flags, packed into the two 32-bit words read back by the LSU.
module input_debounce #(
    parameter int SW_WIDTH        = 18,
    parameter int BTN_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [SW_WIDTH-1:0]  i_io_sw,
    input  logic [BTN_WIDTH-1:0] i_io_btn_n,
    input  logic                 i_ld_en,
    input  logic [31:0]          i_ld_addr,
    output logic [31:0]          b_io_sw,
    output logic [31:0]          b_io_btn
);

    localparam int N     = SW_WIDTH + BTN_WIDTH;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Switches occupy the low bits, buttons (already inverted to pressed = 1) the top.
    logic [N-1:0]         raw;
    logic [N-1:0]         sync_p0;
    logic [N-1:0]         sync_p1;
    logic [N-1:0]         deb;
    logic [N-1:0]         deb_next;
    logic [CNT_W-1:0]     cnt      [N];
    logic [CNT_W-1:0]     cnt_next [N];
    logic [BTN_WIDTH-1:0] pf;
    logic [BTN_WIDTH-1:0] pf_next;
    logic [BTN_WIDTH-1:0] rise;
    logic                 clr;
    logic                 unused_addr_bits;

    assign raw              = {~i_io_btn_n, i_io_sw};
    assign unused_addr_bits = ^i_ld_addr[11:0];

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: any return to the accepted level restarts the run length.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            deb_next[i] = deb[i];
            cnt_next[i] = '0;
            if (sync_p1[i] != deb[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    deb_next[i] = sync_p1[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new debounced press beats a simultaneous clearing load.
    always_comb begin
        rise    = deb_next[N-1:SW_WIDTH] & ~deb[N-1:SW_WIDTH];
        clr     = i_ld_en && (i_ld_addr[31:12] == 20'h10011);
        pf_next = rise | (pf & ~{BTN_WIDTH{clr}});
    end

    // Stage p2: debounced levels, counters and press flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            deb <= '0;
            pf  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_next;
            pf  <= pf_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        b_io_sw                    = '0;
        b_io_sw[SW_WIDTH-1:0]      = deb[SW_WIDTH-1:0];
        b_io_btn                   = '0;
        b_io_btn[BTN_WIDTH-1:0]    = deb[N-1:SW_WIDTH];
        b_io_btn[16 +: BTN_WIDTH]  = pf;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with DEBOUNCE_CYCLES = 4: a vector table
// for reset and switch latency, then hand sequences for the multi-cycle cases.
module tb_input_debounce;

    logic        clk;
    logic        rst;
    logic [17:0] sw;
    logic [3:0]  btn_n;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] b_sw;
    logic [31:0] b_btn;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rst;
        logic [17:0] sw;
        logic [3:0]  btn_n;
        logic [31:0] exp_sw;
        logic [31:0] exp_btn;
    } vec_t;

    vec_t tbl [16];

    input_debounce #(
        .SW_WIDTH       (18),
        .BTN_WIDTH      (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_io_sw    (sw),
        .i_io_btn_n (btn_n),
        .i_ld_en    (ld_en),
        .i_ld_addr  (ld_addr),
        .b_io_sw    (b_sw),
        .b_io_btn   (b_btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        sw      = '0;
        btn_n   = 4'hF;
        ld_en   = 1'b0;
        ld_addr = '0;

        // Reset with everything active, then release; then switch latency.
        for (int k = 0; k < 3; k++)  tbl[k] = '{1'b1, 18'h3FFFF, 4'h0, 32'h0, 32'h0};
        for (int k = 3; k < 8; k++)  tbl[k] = '{1'b0, 18'h3FFFF, 4'h0, 32'h0, 32'h0};
        tbl[8] = '{1'b0, 18'h3FFFF, 4'h0, 32'h0003FFFF, 32'h000F000F};
        tbl[9] = '{1'b1, 18'h0, 4'hF, 32'h0, 32'h0};
        for (int k = 10; k < 15; k++) tbl[k] = '{1'b0, 18'h5, 4'hF, 32'h0, 32'h0};
        tbl[15] = '{1'b0, 18'h5, 4'hF, 32'h5, 32'h0};

        for (int k = 0; k < 16; k++) begin
            rst   = tbl[k].rst;
            sw    = tbl[k].sw;
            btn_n = tbl[k].btn_n;
            step();
            chk($sformatf("vec%0d_sw", k), b_sw, tbl[k].exp_sw);
            chk($sformatf("vec%0d_btn", k), b_btn, tbl[k].exp_btn);
        end

        // Glitch rejection: a 3-cycle pulse never gets accepted.
        rst = 1'b1; sw = '0; btn_n = 4'hF;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            sw = (i <= 3) ? 18'h1 : 18'h0;
            step();
            chk($sformatf("glitch_%0d", i), b_sw, 32'h0);
        end

        // A 6-cycle pulse is accepted, then the release is accepted 6 cycles later.
        for (int i = 1; i <= 14; i++) begin
            sw = (i <= 6) ? 18'h1 : 18'h0;
            step();
            chk($sformatf("pulse6_%0d", i), b_sw, (i >= 6 && i <= 11) ? 32'h1 : 32'h0);
        end

        // Press and release btn[2]; flag stays sticky after release.
        for (int i = 1; i <= 12; i++) begin
            btn_n = (i <= 6) ? 4'hB : 4'hF;
            step();
            chk($sformatf("press_%0d", i), b_btn,
                (i < 6) ? 32'h0 : (i <= 11) ? 32'h00040004 : 32'h00040000);
        end

        // Clearing load returns the pre-clear flags, then reads 0.
        ld_en = 1'b1; ld_addr = 32'h1001_1000;
        #1;
        chk("load_read", b_btn, 32'h00040000);
        step();
        ld_en = 1'b0;
        chk("load_cleared", b_btn, 32'h0);

        // Set/clear collision: pf[1] set earlier, btn[0] rise lands on the load.
        for (int i = 1; i <= 6; i++) begin
            btn_n = 4'hD;
            step();
        end
        chk("coll_btn1", b_btn, 32'h00020002);
        btn_n = 4'hC;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("coll_wait_%0d", i), b_btn, 32'h00020002);
        end
        ld_en = 1'b1; ld_addr = 32'h1001_1000;
        step();
        ld_en = 1'b0;
        chk("coll_set_wins", b_btn, 32'h00010003);

        // Address specificity.
        ld_en = 1'b1; ld_addr = 32'h1001_0000;
        step();
        chk("addr_10010000", b_btn, 32'h00010003);
        ld_addr = 32'h1000_1000;
        step();
        chk("addr_10001000", b_btn, 32'h00010003);
        ld_en = 1'b0; ld_addr = 32'h1001_1000;
        step();
        chk("no_ld_en", b_btn, 32'h00010003);
        ld_en = 1'b1; ld_addr = 32'h1001_1FFC;
        step();
        ld_en = 1'b0;
        chk("addr_10011ffc", b_btn, 32'h00000003);
        chk("sw_unchanged", b_sw, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
